// File: rtl/csa_accum_ctrl.sv
// Streaming multi-operand accumulator: keeps the running total in carry-save form,
// then iterates the same stage until the carry row drains, and presents a binary result.
module csa_accum_ctrl #(
    parameter int N  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_b_en,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic [CW-1:0] out_count,
    output logic          busy,
    output logic [1:0]    o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and payload is held while valid waits for ready.
    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_sum;
    logic [N-1:0]  r_car;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  w_sum_nxt;
    logic [N-1:0]  w_car_nxt;
    logic [CW-1:0] w_cnt_nxt;

    logic [N-1:0]  w_s1;
    logic [N-1:0]  w_co;
    logic [N-1:0]  w_cin;
    logic [N-1:0]  w_cs_sum;
    logic [N-1:0]  w_cs_carry;
    logic [CW:0]   w_cnt_add;
    logic [CW-1:0] w_cnt_sat;

    // First full-adder row; its carries form the 4:2 intra-row chain (bit 0 gets 0).
    assign w_s1  = r_sum ^ r_car ^ in_a;
    assign w_co  = (r_sum & r_car) | (r_sum & in_a) | (r_car & in_a);
    assign w_cin = {w_co[N-2:0], 1'b0};

    assign w_cs_sum   = in_b_en ? (w_s1 ^ in_b ^ w_cin) : w_s1;
    assign w_cs_carry = in_b_en ? ((w_s1 & in_b) | (w_s1 & w_cin) | (in_b & w_cin)) : w_co;

    assign w_cnt_add = {1'b0, r_cnt} + (in_b_en ? (CW+1)'(2) : (CW+1)'(1));
    assign w_cnt_sat = w_cnt_add[CW] ? {CW{1'b1}} : w_cnt_add[CW-1:0];

    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_car_nxt   = r_car;
        w_cnt_nxt   = r_cnt;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_sum     = '0;
        out_count   = '0;
        busy        = 1'b0;

        case (r_state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_sum_nxt = w_cs_sum;
                    w_car_nxt = {w_cs_carry[N-2:0], 1'b0};
                    w_cnt_nxt = w_cnt_sat;
                    if (in_last) begin
                        w_state_nxt = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                busy = 1'b1;
                if (r_car == '0) begin
                    w_state_nxt = OUT;
                end else begin
                    w_sum_nxt = r_sum ^ r_car;
                    w_car_nxt = {(r_sum[N-2:0] & r_car[N-2:0]), 1'b0};
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_sum   = r_sum;
                out_count = r_cnt;
                if (out_ready) begin
                    w_state_nxt = ACC;
                    w_sum_nxt   = '0;
                    w_car_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ACC;
            end
        endcase

        // Flush wins over any beat or pending result in the same cycle.
        if (clr) begin
            w_state_nxt = ACC;
            w_sum_nxt   = '0;
            w_car_nxt   = '0;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACC;
            r_sum   <= '0;
            r_car   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sum   <= w_sum_nxt;
            r_car   <= w_car_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Bench for csa_accum_ctrl: directed cases plus randomized accumulations checked
// against a plain-arithmetic running total; a CW=2 twin checks count saturation.
module tb_csa_accum_ctrl;

    localparam int N   = 8;
    localparam int CW  = 8;
    localparam int CW2 = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic           in_valid;
    logic           in_b_en;
    logic           in_last;
    logic           out_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;

    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [N-1:0]   out_sum;
    logic [CW-1:0]  out_count;
    logic [1:0]     dbg_state;

    logic           in_ready2;
    logic           out_valid2;
    logic           busy2;
    logic [N-1:0]   out_sum2;
    logic [CW2-1:0] out_count2;
    logic [1:0]     dbg_state2;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_q[$];
    int           cnt_q[$];
    int           acc_sum;
    int           acc_cnt;

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    csa_accum_ctrl #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_b_en(in_b_en), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .busy(busy), .o_dbg_state(dbg_state)
    );

    csa_accum_ctrl #(.N(N), .CW(CW2)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_b_en(in_b_en), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
        .out_count(out_count2), .busy(busy2), .o_dbg_state(dbg_state2)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic ben, input logic last);
        check("in_ready_before_beat", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_b_en  = ben;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_b_en  = 1'b0;
        in_a     = '0;
        in_b     = '0;
        acc_sum  = acc_sum + int'(a) + (ben ? int'(b) : 0);
        acc_cnt  = acc_cnt + (ben ? 2 : 1);
        if (last) begin
            exp_q.push_back(N'(acc_sum));
            cnt_q.push_back(acc_cnt);
            acc_sum = 0;
            acc_cnt = 0;
        end
    endtask

    // exp_lat > 0: exact edges from last accept to out_valid; otherwise only the bound.
    task automatic receive(input int exp_lat, input int hold);
        logic [N-1:0] es;
        int ec;
        int edges;
        es    = exp_q.pop_front();
        ec    = cnt_q.pop_front();
        edges = 0;
        while (!out_valid && edges <= N + 1) begin
            check("in_ready_low_resolve", in_ready, 0);
            check("busy_resolve", busy, 1);
            check("out_sum_zero_resolve", out_sum, 0);
            @(posedge clk); #1;
            edges++;
        end
        check("out_valid_within_bound", out_valid, 1);
        if (exp_lat > 0) check("latency", edges, exp_lat);
        else check("resolve_cycles_le_n_plus_1", (edges <= N + 1), 1);
        for (int i = 0; i <= hold; i++) begin
            check("out_valid_held", out_valid, 1);
            check("out_sum", out_sum, es);
            check("out_count", out_count, sat(ec, 255));
            check("out_sum_cw2", out_sum2, es);
            check("out_count_cw2_sat", out_count2, sat(ec, 3));
            check("out_valid_cw2", out_valid2, 1);
            check("in_ready_low_out", in_ready, 0);
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_accept", out_valid, 0);
        check("in_ready_after_accept", in_ready, 1);
        check("out_count_after_accept", out_count, 0);
        check("busy_after_accept", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_b_en   = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        acc_sum   = 0;
        acc_cnt   = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sum", out_sum, 0);
        check("reset_out_count", out_count, 0);
        check("reset_busy", busy, 0);
        check("reset_state_acc", dbg_state, 0);
        check("reset_cw2_in_ready", in_ready2, 1);
        check("reset_cw2_busy", busy2, 0);
        check("reset_cw2_state_acc", dbg_state2, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single 3:2 beat, no carries to resolve
        send_beat(8'h05, 8'h00, 1'b0, 1'b1);
        receive(1, 0);

        // 1 + 1 leaves one carry bit to resolve
        send_beat(8'h01, 8'h00, 1'b0, 1'b0);
        send_beat(8'h01, 8'h00, 1'b0, 1'b1);
        receive(2, 0);

        // 4:2 beat that wraps to zero
        send_beat(8'hFF, 8'h01, 1'b1, 1'b1);
        receive(-1, 0);

        // full ripple
        send_beat(8'h7F, 8'h00, 1'b0, 1'b0);
        send_beat(8'h01, 8'h00, 1'b0, 1'b1);
        receive(-1, 0);

        // backpressure for 5 cycles, then a fresh accumulation must start from zero
        send_beat(8'h20, 8'h10, 1'b1, 1'b1);
        receive(1, 5);
        send_beat(8'h03, 8'h00, 1'b0, 1'b1);
        receive(1, 0);

        // asynchronous reset in the middle of RESOLVE
        send_beat(8'h7F, 8'h00, 1'b0, 1'b0);
        send_beat(8'h01, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("busy_before_async_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_sum", out_sum, 0);
        check("async_rst_out_count", out_count, 0);
        exp_q.delete();
        cnt_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("no_partial_result_after_rst", out_valid, 0);
        send_beat(8'h09, 8'h00, 1'b0, 1'b1);
        receive(1, 0);

        // clr while a result is pending
        send_beat(8'h11, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("clr_out_pending_valid", out_valid, 1);
        check("clr_out_pending_sum", out_sum, 8'h11);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        void'(exp_q.pop_front());
        void'(cnt_q.pop_front());
        check("clr_out_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 1);
        check("clr_out_sum", out_sum, 0);
        check("clr_busy", busy, 0);
        send_beat(8'h04, 8'h00, 1'b0, 1'b1);
        receive(1, 0);

        // clr in ACC drops the beat presented with it and the partial total
        send_beat(8'h30, 8'h00, 1'b0, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_a     = 8'h40;
        in_last  = 1'b1;
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_last  = 1'b0;
        acc_sum  = 0;
        acc_cnt  = 0;
        check("clr_acc_busy", busy, 0);
        send_beat(8'h02, 8'h00, 1'b0, 1'b1);
        receive(1, 0);

        // five single beats saturate the CW=2 count at 3
        for (int j = 0; j < 5; j++) send_beat(8'h01, 8'h00, 1'b0, (j == 4));
        receive(-1, 0);

        // randomized accumulations
        for (int t = 0; t < 30; t++) begin
            int nb;
            nb = $urandom_range(1, 7);
            for (int j = 0; j < nb; j++) begin
                logic [N-1:0] ra;
                logic [N-1:0] rb;
                int gap;
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk); #1;
                end
                ra = ($urandom_range(0, 3) == 0) ? 8'hFF : N'($urandom);
                rb = N'($urandom);
                send_beat(ra, rb, 1'($urandom_range(0, 1)), (j == nb - 1));
            end
            receive(-1, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
